core_pipe_fetch: RTL and testbench

Instruction fetch stage: generates sequential fetch addresses, issues requests on the instruction memory bus and buffers responses in a small FIFO feeding decode. Consumes the control-flow change bus (cf_valid / cf_ack / cf_target) driven by the execute-stage control flow unit. On a redirect it flushes buffered and in-flight fetches and restarts at the new target.

---
 rtl/core_pipe_fetch_if.sv | 40 ++++
 rtl/core_pipe_fetch.sv | 150 +++++++++++++++
 tb/tb_core_pipe_fetch.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pipe_fetch_if.sv
// Fetch stage bus bundle: redirect, instruction memory and decode-side
// handshakes. The fetch stage is the master; its environment the slave.
interface core_pipe_fetch_if #(
    parameter int MEM_ADDR_R = 38
);
    logic                  cf_valid;
    logic                  cf_ack;
    logic [MEM_ADDR_R:0]   cf_target;
    logic                  imem_req;
    logic                  imem_gnt;
    logic [MEM_ADDR_R:0]   imem_addr;
    logic                  imem_recv;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;
    logic                  imem_error;
    logic                  s1_valid;
    logic                  s1_ready;
    logic [31:0]           s1_data;
    logic [MEM_ADDR_R:0]   s1_pc;
    logic                  s1_half;
    logic                  s1_error;

    modport master (
        input  cf_valid, cf_target,
        input  imem_gnt, imem_recv, imem_rdata, imem_error,
        input  s1_ready,
        output cf_ack,
        output imem_req, imem_addr, imem_ack,
        output s1_valid, s1_data, s1_pc, s1_half, s1_error
    );

    modport slave (
        output cf_valid, cf_target,
        output imem_gnt, imem_recv, imem_rdata, imem_error,
        output s1_ready,
        input  cf_ack,
        input  imem_req, imem_addr, imem_ack,
        input  s1_valid, s1_data, s1_pc, s1_half, s1_error
    );
endinterface

// File: rtl/core_pipe_fetch.sv
// Instruction fetch stage: credit-limited sequential fetch into a small
// response FIFO, with redirect flush and discard of in-flight responses.
module core_pipe_fetch #(
    parameter int          MEM_ADDR_R = 38,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] PC_RESET   = 64'h0000_0000_8000_0000
) (
    input logic               g_clk,
    input logic               g_resetn,
    core_pipe_fetch_if.master bus
);
    localparam int AW = MEM_ADDR_R + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [AW-1:0] addr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
        addr_t       pc;
        logic        half;
    } entry_t;

    localparam addr_t PC_INIT = PC_RESET[AW-1:0];

    addr_t          fetch_pc;
    addr_t          rsp_pc;
    cnt_t           outstanding;
    cnt_t           discard;
    cnt_t           fifo_count;
    logic           reset_cycle;
    logic           req_hold;
    logic           redirect_half;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    entry_t         fifo_mem [FIFO_DEPTH];

    sum_t   used;
    logic   credit;
    logic   req;
    logic   fire;
    logic   live;
    logic   drop;
    logic   ack;
    logic   push;
    logic   pop;
    cnt_t   outstanding_nxt;
    cnt_t   discard_nxt;
    cnt_t   count_nxt;
    addr_t  target_w;
    entry_t head;

    // Discarded responses still hold a slot until they arrive.
    assign used   = {1'b0, discard} + {1'b0, outstanding}
                  + {1'b0, fifo_count};
    assign credit = used < sum_t'(FIFO_DEPTH);

    assign req  = req_hold | (!reset_cycle & !bus.cf_valid & credit);
    assign fire = req & bus.imem_gnt;
    assign live = bus.imem_recv & (discard == '0);
    assign drop = bus.imem_recv & (discard != '0);
    assign ack  = bus.cf_valid & !(req & !bus.imem_gnt);
    assign push = live & !ack;
    assign pop  = (fifo_count != '0) & bus.s1_ready & !ack;

    assign target_w = {bus.cf_target[AW-1:2], 2'b00};

    always_comb begin
        outstanding_nxt = outstanding + cnt_t'(fire) - cnt_t'(live);
        discard_nxt     = discard - cnt_t'(drop);
        count_nxt       = fifo_count + cnt_t'(push) - cnt_t'(pop);
        if (ack) begin
            outstanding_nxt = '0;
            discard_nxt     = discard_nxt + outstanding
                            + cnt_t'(fire) - cnt_t'(live);
            count_nxt       = '0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            fetch_pc      <= PC_INIT;
            rsp_pc        <= PC_INIT;
            outstanding   <= '0;
            discard       <= '0;
            fifo_count    <= '0;
            reset_cycle   <= 1'b1;
            req_hold      <= 1'b0;
            redirect_half <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            reset_cycle <= 1'b0;
            req_hold    <= req & !bus.imem_gnt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            fifo_count  <= count_nxt;
            if (ack) begin
                fetch_pc      <= target_w;
                rsp_pc        <= target_w;
                redirect_half <= bus.cf_target[1];
                wr_ptr        <= '0;
                rd_ptr        <= '0;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + addr_t'(4);
                end
                if (push) begin
                    rsp_pc        <= rsp_pc + addr_t'(4);
                    redirect_half <= 1'b0;
                    wr_ptr        <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{
                data:  bus.imem_rdata,
                error: bus.imem_error,
                pc:    rsp_pc,
                half:  redirect_half
            };
        end
    end

    assign head = fifo_mem[rd_ptr];

    assign bus.cf_ack    = ack;
    assign bus.imem_req  = req;
    assign bus.imem_addr = {fetch_pc[AW-1:2], 2'b00};
    assign bus.imem_ack  = 1'b1;
    assign bus.s1_valid  = fifo_count != '0;
    assign bus.s1_data   = head.data;
    assign bus.s1_pc     = head.pc;
    assign bus.s1_half   = head.half;
    assign bus.s1_error  = head.error;

    a_no_overflow : assert property (
        @(posedge g_clk) disable iff (!g_resetn)
        push |-> (fifo_count < cnt_t'(FIFO_DEPTH))
    );
endmodule

// File: tb/tb_core_pipe_fetch.sv
// Bench for core_pipe_fetch: memory responder model plus a scoreboard of
// expected decode-side words, with one task per scenario.
module tb_core_pipe_fetch;
    localparam int R     = 38;
    localparam int AW    = R + 1;
    localparam int DEPTH = 4;

    typedef logic [AW-1:0] addr_t;
    localparam addr_t PC0 = 39'h00_8000_0000;

    typedef struct {
        addr_t addr;
        logic  stale;
    } pend_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        addr_t       pc;
        logic        half;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    core_pipe_fetch_if #(.MEM_ADDR_R(R)) bus ();

    core_pipe_fetch #(
        .MEM_ADDR_R (R),
        .FIFO_DEPTH (DEPTH),
        .PC_RESET   (64'h0000_0000_8000_0000)
    ) dut (
        .g_clk    (clk),
        .g_resetn (resetn),
        .bus      (bus)
    );

    pend_t pend[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    grants = 0;
    logic  recv_en = 1'b0;
    logic  err_en = 1'b0;
    addr_t err_addr = '0;
    addr_t exp_fetch = PC0;
    logic  exp_half = 1'b0;

    logic        s_fire, s_rcv, s_ack, s_rst, s_err;
    addr_t       s_addr, s_tgt;
    logic [31:0] s_data;

    function automatic logic [31:0] word(addr_t a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    // One clock: sample and score at negedge, then update the memory model.
    task automatic tick;
        exp_t  e;
        pend_t h;
        @(negedge clk);
        s_fire = bus.imem_req && bus.imem_gnt;
        s_addr = bus.imem_addr;
        s_rcv  = bus.imem_recv;
        s_data = bus.imem_rdata;
        s_err  = bus.imem_error;
        s_ack  = bus.cf_ack;
        s_tgt  = bus.cf_target;
        s_rst  = !resetn;
        if (s_fire && !s_rst) grants++;
        if (resetn && bus.s1_valid && bus.s1_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_pop: got pc=%h, no word expected",
                         bus.s1_pc);
            end else begin
                e = exp_q.pop_front();
                if ({bus.s1_data, bus.s1_error, bus.s1_pc, bus.s1_half}
                    !== {e.data, e.err, e.pc, e.half}) begin
                    failures++;
                    $display("FAIL sb_word: got d=%h e=%b pc=%h h=%b exp d=%h e=%b pc=%h h=%b",
                             bus.s1_data, bus.s1_error, bus.s1_pc,
                             bus.s1_half, e.data, e.err, e.pc, e.half);
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            pend.delete();
            exp_q.delete();
            exp_half  = 1'b0;
            exp_fetch = PC0;
        end else begin
            if (s_rcv && pend.size() > 0) begin
                h = pend.pop_front();
                if (!h.stale && !s_ack) begin
                    exp_q.push_back('{s_data, s_err, h.addr, exp_half});
                    exp_half = 1'b0;
                end
            end
            if (s_ack) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                exp_q.delete();
                exp_half  = s_tgt[1];
                exp_fetch = {s_tgt[AW-1:2], 2'b00};
            end
            if (s_fire) begin
                pend.push_back('{s_addr, s_ack});
                if (!s_ack) exp_fetch = exp_fetch + addr_t'(4);
            end
        end
        if (recv_en && pend.size() > 0) begin
            bus.imem_recv  = 1'b1;
            bus.imem_rdata = word(pend[0].addr);
            bus.imem_error = err_en && (pend[0].addr == err_addr);
        end else begin
            bus.imem_recv  = 1'b0;
            bus.imem_rdata = '0;
            bus.imem_error = 1'b0;
        end
    endtask

    task automatic drain;
        bus.imem_gnt = 1'b0;
        bus.s1_ready = 1'b1;
        recv_en      = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        #1;
        checks++;
        if ({bus.imem_req, bus.s1_valid, bus.cf_ack} !== 3'b000) begin
            failures++;
            $display("FAIL rst_outputs: req/s1_valid/cf_ack got %b exp 000",
                     {bus.imem_req, bus.s1_valid, bus.cf_ack});
        end
        bus.imem_gnt = 1'b1;
        bus.s1_ready = 1'b1;
        recv_en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            if (i < 3) begin
                checks++;
                if (!bus.imem_req || bus.imem_addr !== PC0 + addr_t'(4 * i)) begin
                    failures++;
                    $display("FAIL seq_addr%0d: got req=%b addr=%h exp %h",
                             i, bus.imem_req, bus.imem_addr,
                             PC0 + addr_t'(4 * i));
                end
            end
            if (i >= 2) begin
                checks++;
                if (!bus.s1_valid || bus.s1_half !== 1'b0 ||
                    bus.s1_pc !== PC0 + addr_t'(4 * (i - 2))) begin
                    failures++;
                    $display("FAIL seq_s1pc%0d: got v=%b pc=%h h=%b exp pc=%h",
                             i, bus.s1_valid, bus.s1_pc, bus.s1_half,
                             PC0 + addr_t'(4 * (i - 2)));
                end
            end
        end
        drain();
    endtask

    task automatic test_backpressure;
        int g0;
        bus.s1_ready = 1'b0;
        bus.imem_gnt = 1'b1;
        g0 = grants;
        repeat (10) tick();
        #1;
        checks++;
        if (grants - g0 != DEPTH || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL bp_credit: got grants=%0d req=%b exp %0d req=0",
                     grants - g0, bus.imem_req, DEPTH);
        end
        bus.s1_ready = 1'b1;
        tick();
        bus.s1_ready = 1'b0;
        g0 = grants;
        repeat (6) tick();
        checks++;
        if (grants - g0 != 1) begin
            failures++;
            $display("FAIL bp_one_more: got grants=%0d exp 1", grants - g0);
        end
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: got %0d words left exp 0", exp_q.size());
        end
    endtask

    task automatic test_redirect;
        int   g0;
        logic seen;
        bus.s1_ready = 1'b0;
        recv_en      = 1'b0;
        bus.imem_gnt = 1'b1;
        g0 = grants;
        repeat (6) tick();
        checks++;
        if (grants - g0 != DEPTH) begin
            failures++;
            $display("FAIL rd_setup: got grants=%0d exp %0d", grants - g0, DEPTH);
        end
        recv_en = 1'b1;
        tick();
        tick();
        recv_en = 1'b0;
        tick();
        bus.cf_valid  = 1'b1;
        bus.cf_target = 39'h00_8000_1002;
        #1;
        checks++;
        if (bus.cf_ack !== 1'b1) begin
            failures++;
            $display("FAIL rd_ack: got %b exp 1", bus.cf_ack);
        end
        tick();
        bus.cf_valid = 1'b0;
        #1;
        checks++;
        if (bus.s1_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== 39'h00_8000_1000) begin
            failures++;
            $display("FAIL rd_restart: got v=%b req=%b addr=%h exp 0 1 0080001000",
                     bus.s1_valid, bus.imem_req, bus.imem_addr);
        end
        recv_en = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            #1;
            seen = bus.s1_valid;
        end
        checks++;
        if (!seen || bus.s1_pc !== 39'h00_8000_1000 || bus.s1_half !== 1'b1 ||
            bus.s1_data !== word(39'h00_8000_1000)) begin
            failures++;
            $display("FAIL rd_first: got v=%b pc=%h h=%b d=%h exp pc=0080001000 h=1",
                     seen, bus.s1_pc, bus.s1_half, bus.s1_data);
        end
        bus.s1_ready = 1'b1;
        tick();
        bus.s1_ready = 1'b0;
        #1;
        checks++;
        if (!bus.s1_valid || bus.s1_pc !== 39'h00_8000_1004 ||
            bus.s1_half !== 1'b0) begin
            failures++;
            $display("FAIL rd_second: got v=%b pc=%h h=%b exp pc=0080001004 h=0",
                     bus.s1_valid, bus.s1_pc, bus.s1_half);
        end
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rd_drain: got %0d words left exp 0", exp_q.size());
        end
    endtask

    task automatic test_stall_redirect;
        bus.imem_gnt = 1'b0;
        bus.s1_ready = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL st_req: got %b exp 1", bus.imem_req);
        end
        bus.cf_valid  = 1'b1;
        bus.cf_target = 39'h00_8000_2000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.cf_ack !== 1'b0 || bus.imem_addr !== exp_fetch) begin
                failures++;
                $display("FAIL st_hold%0d: got ack=%b addr=%h exp ack=0 addr=%h",
                         i, bus.cf_ack, bus.imem_addr, exp_fetch);
            end
            tick();
        end
        bus.imem_gnt = 1'b1;
        #1;
        checks++;
        if (bus.cf_ack !== 1'b1 || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL st_ack: got ack=%b req=%b exp 1 1",
                     bus.cf_ack, bus.imem_req);
        end
        tick();
        bus.cf_valid = 1'b0;
        #1;
        checks++;
        if (bus.imem_addr !== 39'h00_8000_2000) begin
            failures++;
            $display("FAIL st_target: got %h exp 0080002000", bus.imem_addr);
        end
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL st_drain: got %0d words left exp 0", exp_q.size());
        end
    endtask

    task automatic test_error;
        addr_t a0;
        int    k;
        a0       = exp_fetch;
        err_addr = a0 + addr_t'(4);
        err_en   = 1'b1;
        bus.imem_gnt = 1'b1;
        bus.s1_ready = 1'b1;
        recv_en      = 1'b1;
        k = 0;
        repeat (8) begin
            tick();
            #1;
            if (bus.s1_valid) begin
                checks++;
                if (bus.s1_pc !== a0 + addr_t'(4 * k) ||
                    bus.s1_error !== (k == 1)) begin
                    failures++;
                    $display("FAIL err_word%0d: got pc=%h e=%b exp pc=%h e=%b",
                             k, bus.s1_pc, bus.s1_error,
                             a0 + addr_t'(4 * k), (k == 1));
                end
                k++;
            end
        end
        checks++;
        if (k < 4 || !bus.imem_req || bus.imem_addr !== exp_fetch) begin
            failures++;
            $display("FAIL err_continue: got words=%0d req=%b addr=%h exp >=4 1 %h",
                     k, bus.imem_req, bus.imem_addr, exp_fetch);
        end
        err_en = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid;
        bus.s1_ready = 1'b0;
        recv_en      = 1'b0;
        bus.imem_gnt = 1'b1;
        repeat (6) tick();
        recv_en = 1'b1;
        tick();
        recv_en = 1'b0;
        bus.imem_gnt = 1'b0;
        tick();
        checks++;
        if (bus.s1_valid !== 1'b1 || pend.size() != 3) begin
            failures++;
            $display("FAIL rm_setup: got v=%b pend=%0d exp 1 3",
                     bus.s1_valid, pend.size());
        end
        resetn = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.s1_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL rm_clear: got v=%b req=%b exp 0 0",
                     bus.s1_valid, bus.imem_req);
        end
        resetn = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== PC0) begin
            failures++;
            $display("FAIL rm_restart: got req=%b addr=%h exp 1 %h",
                     bus.imem_req, bus.imem_addr, PC0);
        end
        bus.imem_gnt = 1'b1;
        bus.s1_ready = 1'b1;
        recv_en      = 1'b1;
        repeat (6) tick();
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rm_drain: got %0d words left exp 0", exp_q.size());
        end
    endtask

    initial begin
        bus.cf_valid   = 1'b0;
        bus.cf_target  = '0;
        bus.imem_gnt   = 1'b0;
        bus.imem_recv  = 1'b0;
        bus.imem_rdata = '0;
        bus.imem_error = 1'b0;
        bus.s1_ready   = 1'b0;
        test_reset();
        test_backpressure();
        test_redirect();
        test_stall_redirect();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
